// File: rtl/main_memory_controller.sv
// Line-organised backing RAM behind the MMU's external memory bus: one whole-line
// read or byte-masked write per transaction, with a fixed latency and a ready/done handshake.
module main_memory_controller #(
  parameter int XLEN            = 32,
  parameter int BUS_WIDTH_BYTES = 16,
  parameter int DEPTH_LINES     = 1024,
  parameter int LATENCY         = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [XLEN-1:0]              address,
  input  logic                         read,
  input  logic                         write,
  input  logic [BUS_WIDTH_BYTES-1:0]   write_mask,
  input  logic [BUS_WIDTH_BYTES*8-1:0] data_in,
  output logic [BUS_WIDTH_BYTES*8-1:0] data_out,
  output logic                         ready,
  output logic                         done,
  output logic                         error
);

  localparam int LINE_W = BUS_WIDTH_BYTES * 8;
  localparam int OFF_W  = $clog2(BUS_WIDTH_BYTES);
  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam int HI_W   = XLEN - OFF_W - IDX_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                 state_reg;
  logic [CNT_W-1:0]           count_reg;
  logic [IDX_W-1:0]           line_reg;
  logic                       op_write_reg;
  logic                       in_range_reg;
  logic [BUS_WIDTH_BYTES-1:0] mask_reg;
  logic [LINE_W-1:0]          data_reg;
  logic [LINE_W-1:0]          data_out_reg;
  logic                       error_reg;

  logic [LINE_W-1:0] mem [DEPTH_LINES];

  logic [IDX_W-1:0]           addr_line;
  logic                       addr_in_range;
  logic                       accept;
  logic                       load_read;
  logic                       commit;
  logic [IDX_W-1:0]           rd_line;
  logic                       rd_in_range;
  logic [BUS_WIDTH_BYTES-1:0] byte_we;
  logic                       unused_addr_bits;

  assign addr_line        = address[OFF_W +: IDX_W];
  assign unused_addr_bits = ^address[OFF_W-1:0];

  generate
    if (HI_W > 0) begin : g_hi
      assign addr_in_range = (address[XLEN-1 -: HI_W] == '0);
    end else begin : g_nohi
      assign addr_in_range = 1'b1;
    end
  endgenerate

  assign accept = (state_reg == IDLE) && (read ^ write);

  // The RAM read happens on the edge that enters DONE; with LATENCY=1 that is the
  // accept edge itself, so the live address has to be used instead of the latched one.
  always_comb begin
    rd_line     = line_reg;
    rd_in_range = in_range_reg;
    load_read   = 1'b0;
    if (state_reg == IDLE) begin
      rd_line     = addr_line;
      rd_in_range = addr_in_range;
      load_read   = (LATENCY == 1) && accept && read;
    end else if (state_reg == WAIT) begin
      load_read = (count_reg == CNT_W'(1)) && !op_write_reg;
    end
  end

  assign commit = (state_reg == DONE) && op_write_reg && in_range_reg && !reset;

  generate
    for (genvar gi = 0; gi < BUS_WIDTH_BYTES; gi++) begin : g_byte_we
      assign byte_we[gi] = commit && mask_reg[gi];
    end
  endgenerate

  // count_reg counts the cycles left before DONE; it leaves WAIT as it reaches zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      error_reg    <= 1'b0;
      data_out_reg <= '0;
    end else begin
      error_reg <= (state_reg == IDLE) && read && write;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) state_reg <= DONE;
            else              state_reg <= WAIT;
            count_reg <= CNT_W'(LATENCY - 1);
          end
        end
        WAIT: begin
          count_reg <= count_reg - 1'b1;
          if (count_reg == CNT_W'(1)) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (load_read) data_out_reg <= rd_in_range ? mem[rd_line] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      line_reg     <= addr_line;
      op_write_reg <= write;
      in_range_reg <= addr_in_range;
      mask_reg     <= write_mask;
      data_reg     <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < BUS_WIDTH_BYTES; i++) begin
      if (byte_we[i]) mem[line_reg][8*i +: 8] <= data_reg[8*i +: 8];
    end
  end

  assign data_out = data_out_reg;
  assign ready    = (state_reg == IDLE);
  assign done     = (state_reg == DONE);
  assign error    = error_reg;

endmodule

// File: tb/tb_main_memory_controller.sv
// Self-checking bench for main_memory_controller: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a line-array reference model.
module tb_main_memory_controller;

  localparam int LAT = 4;
  localparam logic [127:0] D1  = 128'h0123456789ABCDEF0011223344556677;
  localparam logic [127:0] D1M = 128'h0123456789ABCDEF00112233FFFFFFFF;
  localparam logic [127:0] D2  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D3  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] D2M = 128'hF0112233445566778899AABBCCDDEE0F;
  localparam logic [127:0] D4  = 128'hCAFEBABEDEADBEEF1234567887654321;
  localparam logic [127:0] D5  = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  address;
  logic         read;
  logic         write;
  logic [15:0]  write_mask;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         ready;
  logic         done;
  logic         error;

  main_memory_controller #(
    .XLEN(32), .BUS_WIDTH_BYTES(16), .DEPTH_LINES(1024), .LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .write_mask(write_mask), .data_in(data_in), .data_out(data_out),
    .ready(ready), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one entry per line, out-of-range addresses read as zero and ignore writes.
  logic [127:0] model_mem [1024];

  function automatic logic [127:0] model_read(input logic [31:0] a);
    if (a[31:14] != 18'd0) return '0;
    return model_mem[a[13:4]];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d);
    if (a[31:14] == 18'd0) begin
      for (int b = 0; b < 16; b++)
        if (m[b]) model_mem[a[13:4]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // One transaction from an IDLE negedge back to the next IDLE negedge.
  task automatic txn(input logic [31:0] a, input logic rd, input logic wr, input logic [15:0] m,
                     input logic [127:0] d, output int lat, output logic [127:0] q,
                     output logic rdy_before, output logic rdy_wait);
    address = a; read = rd; write = wr; write_mask = m; data_in = d;
    rdy_before = ready;
    rdy_wait = 1'b1;
    lat = -1;
    q = '0;
    @(posedge clock);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 1) rdy_wait = ready;
      if (done) begin
        lat = c;
        q = data_out;
        break;
      end
    end
    read = 1'b0; write = 1'b0;
    @(negedge clock);
  endtask

  typedef struct {
    string        name;
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [15:0]  mask;
    logic [127:0] wdata;
    logic [127:0] exp_q;
    logic         exp_err;
  } vec_t;

  vec_t vecs[14];

  int           lat;
  logic [127:0] q;
  logic         rb;
  logic         rw;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           first;
    int           second;
    logic [127:0] q1;
    logic         seen_done;
    logic         seen_err;
    logic [127:0] last_rd;
    logic         have_rd;

    vecs[0]  = '{"wr_full_40",    32'h40,    1'b0, 1'b1, 16'hFFFF, D1,   '0,  1'b0};
    vecs[1]  = '{"rd_4c",         32'h4C,    1'b1, 1'b0, 16'h0000, '0,   D1,  1'b0};
    vecs[2]  = '{"wr_mask_000f",  32'h40,    1'b0, 1'b1, 16'h000F, '1,   '0,  1'b0};
    vecs[3]  = '{"rd_40_merged",  32'h40,    1'b1, 1'b0, 16'h0000, '0,   D1M, 1'b0};
    vecs[4]  = '{"rd_wr_both",    32'h40,    1'b1, 1'b1, 16'hFFFF, '0,   '0,  1'b1};
    vecs[5]  = '{"rd_after_err",  32'h40,    1'b1, 1'b0, 16'h0000, '0,   D1M, 1'b0};
    vecs[6]  = '{"wr_line0",      32'h0,     1'b0, 1'b1, 16'hFFFF, D2,   '0,  1'b0};
    vecs[7]  = '{"wr_oor",        32'h10000, 1'b0, 1'b1, 16'hFFFF, D3,   '0,  1'b0};
    vecs[8]  = '{"rd_oor",        32'h10000, 1'b1, 1'b0, 16'h0000, '0,   '0,  1'b0};
    vecs[9]  = '{"rd_line0",      32'h0,     1'b1, 1'b0, 16'h0000, '0,   D2,  1'b0};
    vecs[10] = '{"wr_mask_zero",  32'h0,     1'b0, 1'b1, 16'h0000, D3,   '0,  1'b0};
    vecs[11] = '{"rd_line0_same", 32'h4,     1'b1, 1'b0, 16'h0000, '0,   D2,  1'b0};
    vecs[12] = '{"wr_mask_8001",  32'h8,     1'b0, 1'b1, 16'h8001, D3,   '0,  1'b0};
    vecs[13] = '{"rd_line0_mrg",  32'hC,     1'b1, 1'b0, 16'h0000, '0,   D2M, 1'b0};

    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; write_mask = '0; data_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_ready", 128'(ready), 128'(1));
    check("reset_done", 128'(done), 128'(0));
    check("reset_error", 128'(error), 128'(0));
    check("reset_data_out", data_out, '0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].exp_err) begin
        address = vecs[i].addr; read = 1'b1; write = 1'b1;
        write_mask = vecs[i].mask; data_in = vecs[i].wdata;
        @(posedge clock);
        @(negedge clock);
        check({vecs[i].name, "_error"}, 128'(error), 128'(1));
        check({vecs[i].name, "_ready"}, 128'(ready), 128'(1));
        read = 1'b0; write = 1'b0;
        seen_done = 1'b0; seen_err = 1'b0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clock);
          seen_done |= done;
          seen_err  |= error;
        end
        check({vecs[i].name, "_no_done"}, 128'(seen_done), 128'(0));
        check({vecs[i].name, "_err_pulse"}, 128'(seen_err), 128'(0));
      end else begin
        txn(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].mask, vecs[i].wdata, lat, q, rb, rw);
        $display("vec %0d %s: addr=%h rd=%0d wr=%0d latency=%0d q=%h",
                 i, vecs[i].name, vecs[i].addr, vecs[i].rd, vecs[i].wr, lat, q);
        check({vecs[i].name, "_lat"}, 128'(lat), 128'(LAT));
        check({vecs[i].name, "_ready_idle"}, 128'(rb), 128'(1));
        check({vecs[i].name, "_ready_busy"}, 128'(rw), 128'(0));
        if (vecs[i].rd) check({vecs[i].name, "_data"}, q, vecs[i].exp_q);
      end
    end

    // Reset two cycles into a write: no completion and the old line survives.
    txn(32'h80, 1'b0, 1'b1, 16'hFFFF, D4, lat, q, rb, rw);
    check("init_80_lat", 128'(lat), 128'(LAT));
    address = 32'h80; write = 1'b1; write_mask = 16'hFFFF; data_in = D5;
    seen_done = 1'b0;
    @(posedge clock);
    @(negedge clock);
    seen_done |= done;
    @(negedge clock);
    seen_done |= done;
    reset = 1'b1; write = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      seen_done |= done;
    end
    check("abort_no_done", 128'(seen_done), 128'(0));
    check("abort_ready", 128'(ready), 128'(1));
    check("abort_data_out_cleared", data_out, '0);
    txn(32'h80, 1'b1, 1'b0, 16'h0, '0, lat, q, rb, rw);
    $display("abort readback: latency=%0d q=%h", lat, q);
    check("abort_readback", q, D4);

    // Read held across done: second access accepted in the IDLE cycle after DONE.
    address = 32'h4C; read = 1'b1; write = 1'b0;
    first = -1; second = -1; q1 = '0;
    @(posedge clock);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (done) begin
        if (first < 0) begin
          first = c;
          q1 = data_out;
        end else begin
          second = c;
          break;
        end
      end
    end
    read = 1'b0;
    @(negedge clock);
    $display("back-to-back: first done=%0d second done=%0d", first, second);
    check("b2b_first_lat", 128'(first), 128'(LAT));
    check("b2b_gap", 128'(second - first), 128'(LAT + 1));
    check("b2b_data", q1, D1M);

    // Randomized phase against the reference model, using lines 0..7 plus aliases out of range.
    for (int l = 0; l < 8; l++) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      txn(32'(l) << 4, 1'b0, 1'b1, 16'hFFFF, d, lat, q, rb, rw);
      model_write(32'(l) << 4, 16'hFFFF, d);
      check("rand_init_lat", 128'(lat), 128'(LAT));
    end
    have_rd = 1'b0;
    last_rd = '0;
    for (int n = 0; n < 150; n++) begin
      logic [31:0]  a;
      logic         rd;
      logic [15:0]  m;
      logic [127:0] d;
      a = (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = a | (32'd1 << $urandom_range(14, 31));
      rd = 1'($urandom_range(0, 1));
      m  = 16'($urandom);
      d  = {$urandom, $urandom, $urandom, $urandom};
      txn(a, rd, !rd, m, d, lat, q, rb, rw);
      $display("rand %0d: addr=%h %s mask=%h latency=%0d q=%h", n, a, rd ? "rd" : "wr", m, lat, q);
      check("rand_lat", 128'(lat), 128'(LAT));
      if (rd) begin
        last_rd = model_read(a);
        have_rd = 1'b1;
        check("rand_read", q, last_rd);
      end else begin
        model_write(a, m, d);
        if (have_rd) check("rand_hold", data_out, last_rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
